// File: rtl/mst_strm_gen.sv
// Streaming test-pattern source for FIFO channel 0: answers gen0req with framed {last, payload}
// words. Optional payload error injection is compiled in with GEN_ERRINJ_EN.
module mst_strm_gen #(
  parameter int unsigned DWIDTH    = 13,
  parameter logic [11:0] LFSR_SEED = 12'hACE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              genstart,
  input  logic              genstop,
  input  logic [1:0]        genmode,
  input  logic [11:0]       genpat,
  input  logic [15:0]       genlen,
  input  logic [15:0]       genpkts,
  input  logic              gen0req,
`ifdef GEN_ERRINJ_EN
  input  logic              errinj,
`endif
  output logic [DWIDTH-1:0] gen0dat,
  output logic              genbusy,
  output logic              gendone,
  output logic              generr,
  output logic [31:0]       genwcnt
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [1:0] ModeCnt  = 2'd0;
  localparam logic [1:0] ModeLfsr = 2'd1;
  localparam logic [1:0] ModeFix  = 2'd2;
  localparam logic [1:0] ModeWalk = 2'd3;

  // An all-zero seed would lock the LFSR, so it is forced to 1.
  localparam logic [11:0] SeedEff = (LFSR_SEED == 12'h000) ? 12'h001 : LFSR_SEED;

  state_e            st_q, st_d;
  logic [1:0]        mode_q, mode_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       pkts_q, pkts_d;
  logic [15:0]       wip_q, wip_d;
  logic [15:0]       pkt_q, pkt_d;
  logic [11:0]       pat_q, pat_d;
  logic [DWIDTH-1:0] dat_q, dat_d;
  logic [31:0]       wcnt_q, wcnt_d;
  logic              err_q, err_d;

  logic              serve;
  logic              start;
  logic              last;
  logic              last_pkt;
  logic [15:0]       len_m1;
  logic [11:0]       seed;
  logic              inj;

  function automatic logic [11:0] pat_next(input logic [1:0] m, input logic [11:0] d);
    logic [11:0] n;
    unique case (m)
      ModeCnt:  n = d + 12'd1;
      ModeLfsr: n = {d[10:0], d[11] ^ d[10] ^ d[9] ^ d[3]};
      ModeFix:  n = d;
      default:  n = {d[10:0], d[11]};
    endcase
    return n;
  endfunction

  always_comb begin
    unique case (genmode)
      ModeCnt:  seed = 12'h000;
      ModeLfsr: seed = SeedEff;
      ModeFix:  seed = genpat;
      ModeWalk: seed = 12'h001;
      default:  seed = 12'h000;
    endcase
  end

  assign len_m1   = (len_q == 16'd0) ? 16'd0 : len_q - 16'd1;
  assign last     = (wip_q == len_m1);
  assign last_pkt = (pkts_q != 16'd0) && (pkt_q == pkts_q - 16'd1);
  assign start    = (st_q != StRun) && genstart && !genstop;
  assign serve    = (st_q == StRun) && gen0req && !genstop;

`ifdef GEN_ERRINJ_EN
  logic arm_q, arm_d;

  // Arming is one-shot: a served word consumes it, pulses while armed are dropped.
  always_comb begin
    arm_d = arm_q;
    if (serve) begin
      arm_d = 1'b0;
    end
    if (errinj && !arm_q) begin
      arm_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q <= 1'b0;
    end else begin
      arm_q <= arm_d;
    end
  end

  assign inj = arm_q;
`else
  assign inj = 1'b0;
`endif

  always_comb begin
    st_d   = st_q;
    mode_d = mode_q;
    len_d  = len_q;
    pkts_d = pkts_q;
    wip_d  = wip_q;
    pkt_d  = pkt_q;
    pat_d  = pat_q;
    dat_d  = dat_q;
    wcnt_d = wcnt_q;
    err_d  = err_q;

    unique case (st_q)
      StIdle, StDone: begin
        if (start) begin
          st_d   = StRun;
          mode_d = genmode;
          len_d  = genlen;
          pkts_d = genpkts;
          wip_d  = 16'd0;
          pkt_d  = 16'd0;
          pat_d  = seed;
          wcnt_d = 32'd0;
          err_d  = 1'b0;
        end
      end
      StRun: begin
        if (genstop) begin
          st_d = StIdle;
        end else if (gen0req) begin
          dat_d           = '0;
          dat_d[DWIDTH-1] = last;
          dat_d[11:0]     = {pat_q[11:1], pat_q[0] ^ inj};
          pat_d           = pat_next(mode_q, pat_q);
          wcnt_d          = wcnt_q + 32'd1;
          if (last) begin
            wip_d = 16'd0;
            pkt_d = pkt_q + 16'd1;
            if (last_pkt) begin
              st_d = StDone;
            end
          end else begin
            wip_d = wip_q + 16'd1;
          end
        end
      end
      default: st_d = StIdle;
    endcase

    // A request that cannot be served is flagged, even in a start cycle.
    if (gen0req && !serve) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= StIdle;
      mode_q <= 2'd0;
      len_q  <= 16'd0;
      pkts_q <= 16'd0;
      wip_q  <= 16'd0;
      pkt_q  <= 16'd0;
      pat_q  <= 12'd0;
      dat_q  <= '0;
      wcnt_q <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      mode_q <= mode_d;
      len_q  <= len_d;
      pkts_q <= pkts_d;
      wip_q  <= wip_d;
      pkt_q  <= pkt_d;
      pat_q  <= pat_d;
      dat_q  <= dat_d;
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end

  assign gen0dat = dat_q;
  assign genbusy = (st_q == StRun);
  assign gendone = (st_q == StDone);
  assign generr  = err_q;
  assign genwcnt = wcnt_q;

endmodule

// File: tb/tb_mst_strm_gen.sv
// Directed bench for mst_strm_gen; a second instance with a zero LFSR seed checks the override.
module tb_mst_strm_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        genstart = 1'b0;
  logic        genstop = 1'b0;
  logic [1:0]  genmode = 2'd0;
  logic [11:0] genpat = 12'h5A5;
  logic [15:0] genlen = 16'd0;
  logic [15:0] genpkts = 16'd0;
  logic        gen0req = 1'b0;
  logic        errinj = 1'b0;

  logic [12:0] gen0dat, gen0dat_z;
  logic        genbusy, genbusy_z;
  logic        gendone, gendone_z;
  logic        generr, generr_z;
  logic [31:0] genwcnt, genwcnt_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mst_strm_gen #(.DWIDTH(13), .LFSR_SEED(12'hACE)) dut (
    .clk(clk), .rst(rst), .genstart(genstart), .genstop(genstop), .genmode(genmode),
    .genpat(genpat), .genlen(genlen), .genpkts(genpkts), .gen0req(gen0req),
`ifdef GEN_ERRINJ_EN
    .errinj(errinj),
`endif
    .gen0dat(gen0dat), .genbusy(genbusy), .gendone(gendone), .generr(generr),
    .genwcnt(genwcnt)
  );

  mst_strm_gen #(.DWIDTH(13), .LFSR_SEED(12'h000)) dut_z (
    .clk(clk), .rst(rst), .genstart(genstart), .genstop(genstop), .genmode(genmode),
    .genpat(genpat), .genlen(genlen), .genpkts(genpkts), .gen0req(gen0req),
`ifdef GEN_ERRINJ_EN
    .errinj(errinj),
`endif
    .gen0dat(gen0dat_z), .genbusy(genbusy_z), .gendone(gendone_z), .generr(generr_z),
    .genwcnt(genwcnt_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [15:0] l, input logic [15:0] p);
    genmode  = m;
    genlen   = l;
    genpkts  = p;
    genstart = 1'b1;
    tick();
    genstart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (gen0dat !== 13'h0 || genbusy !== 1'b0 || gendone !== 1'b0 || generr !== 1'b0 ||
        genwcnt !== 32'd0) begin
      errors++;
      $display("FAIL reset: dat=%h busy=%b done=%b err=%b wcnt=%0d, want all 0",
               gen0dat, genbusy, gendone, generr, genwcnt);
    end
    checks++;
    if (gen0dat_z !== 13'h0 || genbusy_z !== 1'b0 || gendone_z !== 1'b0 ||
        generr_z !== 1'b0 || genwcnt_z !== 32'd0) begin
      errors++;
      $display("FAIL reset_z: dat=%h busy=%b done=%b err=%b wcnt=%0d, want all 0",
               gen0dat_z, genbusy_z, gendone_z, generr_z, genwcnt_z);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_counter_packets();
    logic [12:0] exp;
    do_start(2'd0, 16'd4, 16'd2);
    checks++;
    if (genbusy !== 1'b1) begin
      errors++;
      $display("FAIL cnt_busy: got %b want 1", genbusy);
    end
    gen0req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i < 8) begin
        exp = {(i % 4 == 3) ? 1'b1 : 1'b0, 12'(i)};
        checks++;
        if (gen0dat !== exp) begin
          errors++;
          $display("FAIL cnt_word%0d: got %h want %h", i, gen0dat, exp);
        end
      end
    end
    gen0req = 1'b0;
    checks++;
    if (gendone !== 1'b1 || genbusy !== 1'b0) begin
      errors++;
      $display("FAIL cnt_done: done=%b busy=%b want done=1 busy=0", gendone, genbusy);
    end
    checks++;
    if (genwcnt !== 32'd8) begin
      errors++;
      $display("FAIL cnt_wcnt: got %0d want 8", genwcnt);
    end
    checks++;
    if (generr !== 1'b1) begin
      errors++;
      $display("FAIL cnt_err: got %b want 1", generr);
    end
    checks++;
    if (gen0dat !== 13'h1007) begin
      errors++;
      $display("FAIL cnt_hold: got %h want 1007", gen0dat);
    end
  endtask

  task automatic test_walking_one();
    logic [11:0] w;
    logic [12:0] exp;
    do_start(2'd3, 16'd0, 16'd0);
    checks++;
    if (generr !== 1'b0 || gendone !== 1'b0) begin
      errors++;
      $display("FAIL walk_clear: err=%b done=%b want 0 0", generr, gendone);
    end
    w = 12'h001;
    for (int k = 0; k < 13; k++) begin
      exp = {1'b1, w};
      gen0req = 1'b1;
      tick();
      gen0req = 1'b0;
      checks++;
      if (gen0dat !== exp) begin
        errors++;
        $display("FAIL walk_word%0d: got %h want %h", k, gen0dat, exp);
      end
      tick();
      checks++;
      if (gen0dat !== exp) begin
        errors++;
        $display("FAIL walk_hold%0d: got %h want %h", k, gen0dat, exp);
      end
      w = {w[10:0], w[11]};
    end
    checks++;
    if (genwcnt !== 32'd13 || generr !== 1'b0) begin
      errors++;
      $display("FAIL walk_wcnt: wcnt=%0d err=%b want 13 0", genwcnt, generr);
    end
  endtask

  task automatic test_abort();
    gen0req = 1'b1;
    genstop = 1'b1;
    tick();
    gen0req = 1'b0;
    genstop = 1'b0;
    checks++;
    if (genbusy !== 1'b0 || gendone !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b want 0 0", genbusy, gendone);
    end
    checks++;
    if (gen0dat !== 13'h1001 || genwcnt !== 32'd13) begin
      errors++;
      $display("FAIL abort_hold: dat=%h wcnt=%0d want 1001 13", gen0dat, genwcnt);
    end
    checks++;
    if (generr !== 1'b1) begin
      errors++;
      $display("FAIL abort_err: got %b want 1", generr);
    end
  endtask

  task automatic test_start_stop_same();
    genmode  = 2'd0;
    genstart = 1'b1;
    genstop  = 1'b1;
    tick();
    genstart = 1'b0;
    genstop  = 1'b0;
    tick();
    checks++;
    if (genbusy !== 1'b0 || generr !== 1'b1 || genwcnt !== 32'd13) begin
      errors++;
      $display("FAIL startstop: busy=%b err=%b wcnt=%0d want 0 1 13", genbusy, generr, genwcnt);
    end
  endtask

  task automatic test_lfsr();
    logic [12:0] exp_a [3];
    logic [12:0] exp_z [3];
    exp_a[0] = 13'h0ACE; exp_a[1] = 13'h159D; exp_a[2] = 13'h0B3A;
    exp_z[0] = 13'h0001; exp_z[1] = 13'h1002; exp_z[2] = 13'h0004;
    do_start(2'd1, 16'd2, 16'd0);
    checks++;
    if (generr !== 1'b0 || genwcnt !== 32'd0) begin
      errors++;
      $display("FAIL lfsr_clear: err=%b wcnt=%0d want 0 0", generr, genwcnt);
    end
    gen0req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gen0dat !== exp_a[i]) begin
        errors++;
        $display("FAIL lfsr_word%0d: got %h want %h", i, gen0dat, exp_a[i]);
      end
      checks++;
      if (gen0dat_z !== exp_z[i]) begin
        errors++;
        $display("FAIL lfsr_zero_seed%0d: got %h want %h", i, gen0dat_z, exp_z[i]);
      end
    end
    gen0req = 1'b0;
    checks++;
    if (genbusy !== 1'b1 || genwcnt !== 32'd3) begin
      errors++;
      $display("FAIL lfsr_run: busy=%b wcnt=%0d want 1 3", genbusy, genwcnt);
    end
  endtask

  task automatic test_reset_midrun();
    genstop = 1'b1;
    tick();
    genstop = 1'b0;
    do_start(2'd0, 16'd4, 16'd0);
    gen0req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    gen0req = 1'b0;
    checks++;
    if (gen0dat !== 13'h0004 || genwcnt !== 32'd5) begin
      errors++;
      $display("FAIL midrun_pre: dat=%h wcnt=%0d want 0004 5", gen0dat, genwcnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (gen0dat !== 13'h0 || genbusy !== 1'b0 || gendone !== 1'b0 || generr !== 1'b0 ||
        genwcnt !== 32'd0) begin
      errors++;
      $display("FAIL midrun_rst: dat=%h busy=%b done=%b err=%b wcnt=%0d want all 0",
               gen0dat, genbusy, gendone, generr, genwcnt);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (genbusy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_idle: busy=%b want 0", genbusy);
    end
    do_start(2'd0, 16'd4, 16'd0);
    gen0req = 1'b1;
    tick();
    gen0req = 1'b0;
    checks++;
    if (gen0dat !== 13'h0000 || genbusy !== 1'b1 || genwcnt !== 32'd1) begin
      errors++;
      $display("FAIL midrun_restart: dat=%h busy=%b wcnt=%0d want 0000 1 1",
               gen0dat, genbusy, genwcnt);
    end
  endtask

`ifdef GEN_ERRINJ_EN
  task automatic test_errinj();
    logic [12:0] exp [4];
    exp[0] = 13'h0000; exp[1] = 13'h0001; exp[2] = 13'h0003; exp[3] = 13'h0003;
    genstop = 1'b1;
    tick();
    genstop = 1'b0;
    do_start(2'd0, 16'd8, 16'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        errinj = 1'b1;
        tick();
        errinj = 1'b0;
      end
      gen0req = 1'b1;
      tick();
      gen0req = 1'b0;
      checks++;
      if (gen0dat !== exp[i]) begin
        errors++;
        $display("FAIL errinj_word%0d: got %h want %h", i, gen0dat, exp[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_counter_packets();
    test_walking_one();
    test_abort();
    test_start_stop_same();
    test_lfsr();
    test_reset_midrun();
`ifdef GEN_ERRINJ_EN
    test_errinj();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
